hyperbus_cs_seq: RTL and testbench
==================================

Name: hyperbus_cs_seq

Overview:
Parametrised chip-select and clock-enable sequencer in the 90°-shifted clock domain of the HyperBus PHY. It replaces the fixed one-cycle CS register with programmable timing:
- CS setup (t_CSS), CS hold (t_CSH), CS-high recovery (t_CSHI)
- optional maximum CS-low time (t_CSM) enforcement
It drives hyper_cs_no for NumChips devices and the differential-clock enable. The transaction controller handshakes each transfer against it.

Parameters:
NumChips, 2, number of HyperBus chip selects (>=1)
CntWidth, 4, width of t_CSS/t_CSH/t_CSHI cycle counts
CsmWidth, 10, width of the t_CSM cycle count
ChipIdxWidth, $clog2(NumChips) (min 1), width of chip index

Ports:
clk_90_i  in  1  90°-shifted PHY clock
rst_ni  in  1  reset, asynchronous, active-low
cfg_t_css_i  in  CntWidth  CS setup cycles minus one
cfg_t_csh_i  in  CntWidth  CS hold cycles minus one
cfg_t_cshi_i  in  CntWidth  CS high recovery cycles minus one
cfg_t_csm_i  in  CsmWidth  max clock-active cycles per CS assertion
cfg_csm_ena_i  in  1  enable t_CSM enforcement
req_valid_i  in  1  transfer request
req_ready_o  out  1  sequencer idle, request accepted
req_chip_i  in  ChipIdxWidth  target chip index
release_i  in  1  controller finished transfer
abort_i  in  1  immediate termination
active_o  out  1  clock running, data phase allowed
ck_ena_o  out  1  enable for differential clock output
hyper_cs_no  out  NumChips  active-low chip selects
csm_expired_o  out  1  one-cycle pulse: t_CSM forced release
req_err_o  out  1  one-cycle pulse: chip index out of range

Behaviour:
- Reset values:
  - hyper_cs_no = all 1; ck_ena_o, active_o, csm_expired_o, req_err_o = 0.
  - State IDLE; req_ready_o = 1 once reset is released.
- All outputs are registered except req_ready_o, which is decoded as state==IDLE.
- Accept = req_valid_i & req_ready_o. On accept, the chip index and all cfg_* values are latched. Config changes mid-transfer have no effect.
- req_chip_i >= NumChips on accept: req_err_o pulses next cycle, state stays IDLE, no CS asserted.
- IDLE: CS all high, ck_ena_o 0. On valid accept -> SETUP, counter = t_CSS; the selected CS goes low on the next edge.
- SETUP: CS low, ck_ena_o 0. Counter decrements each cycle; at 0 -> ACTIVE. This gives exactly t_CSS+1 CS-low cycles before ck_ena_o rises.
- ACTIVE: ck_ena_o = active_o = 1, CS low; csm counter increments from 0.
  - release_i -> HOLD, counter = t_CSH. ck_ena_o falls on the next edge.
  - cfg_csm_ena & csm counter == t_CSM-1 & !release_i -> HOLD, with a csm_expired_o pulse coincident with ck_ena_o falling.
  - release_i and expiry in the same cycle: release wins, no pulse.
  - t_CSM = 0 with enforcement enabled is treated as 1.
- HOLD: CS low, ck_ena_o 0 for t_CSH+1 cycles -> RECOVER, counter = t_CSHI; CS goes high on the transition edge.
- RECOVER: CS high, req_ready_o 0 for t_CSHI+1 cycles -> IDLE.
- abort_i in SETUP/ACTIVE/HOLD: next edge CS all high, ck_ena_o/active_o 0, -> RECOVER (full t_CSHI+1 still enforced). abort_i in IDLE/RECOVER is ignored. abort has priority over release and expiry; no csm pulse on abort.
- release_i outside ACTIVE is ignored.
- At most one CS is low at any time; CS never changes while ck_ena_o = 1.
- Async reset at any point: outputs return to reset values immediately, and the in-flight transfer is dropped.

Decomposition:
- hyperbus_pkg:
  - hyper_cs_state_e (IDLE, SETUP, ACTIVE, HOLD, RECOVER)
  - hyper_cs_timing_t struct {t_css, t_csh, t_cshi, t_csm, csm_ena}
  - default timing constants
- One sub-module, hyperbus_down_counter: loadable down-counter with zero flag, parametrised width. It is shared by the SETUP/HOLD/RECOVER phases. The t_CSM up-counter stays inline.

Test Plan:
- Reset, then cfg t_css=2, t_csh=1, t_cshi=3, chip 1, release after 5 ACTIVE cycles:
  - hyper_cs_no[1] low 3 cycles before ck_ena_o
  - ck_ena_o high 5 cycles
  - CS low 2 more cycles
  - req_ready_o low 4 cycles
  - hyper_cs_no[0] stays 1 throughout
- csm_ena=1, t_csm=8, no release -> ck_ena_o high exactly 8 cycles, csm_expired_o single pulse, then HOLD/RECOVER timing as programmed.
- release_i in the same cycle as t_CSM expiry -> normal HOLD, csm_expired_o stays 0.
- abort_i in cycle 1 of SETUP with t_cshi=2 -> CS high next edge, ck_ena_o never asserts, req_ready_o returns after 3 cycles. Repeat the abort in ACTIVE and in HOLD.
- NumChips=4, req_chip=5 -> req_err_o pulse, all CS stay high, next valid request is accepted normally. Back-to-back requests held valid -> one accept per transaction, with no CS overlap.
- Change cfg_t_csh_i from 1 to 7 during ACTIVE -> the current transfer holds 2 cycles; the next transfer holds 8. Async reset asserted mid-ACTIVE -> CS all 1 and ck_ena_o 0 immediately.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus PHY chip-select sequencer.
package hyperbus_pkg;

  localparam int unsigned TimCntWidth = 8;
  localparam int unsigned TimCsmWidth = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACTIVE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } hyper_cs_state_e;

  // Latched per-transfer timing; fields are wide enough for any supported counter width.
  typedef struct packed {
    logic [TimCntWidth-1:0] t_css;
    logic [TimCntWidth-1:0] t_csh;
    logic [TimCntWidth-1:0] t_cshi;
    logic [TimCsmWidth-1:0] t_csm;
    logic                   csm_ena;
  } hyper_cs_timing_t;

  localparam logic [TimCntWidth-1:0] DefTCss  = 8'd1;
  localparam logic [TimCntWidth-1:0] DefTCsh  = 8'd0;
  localparam logic [TimCntWidth-1:0] DefTCshi = 8'd1;
  localparam logic [TimCsmWidth-1:0] DefTCsm  = 16'd0;

  localparam hyper_cs_timing_t DefaultTiming = '{
    t_css:   DefTCss,
    t_csh:   DefTCsh,
    t_cshi:  DefTCshi,
    t_csm:   DefTCsm,
    csm_ena: 1'b0
  };

  // Index of the last allowed clock-active cycle; a zero limit behaves like one.
  function automatic logic [TimCsmWidth-1:0] csm_last_cycle(input logic [TimCsmWidth-1:0] t_csm);
    return (t_csm == '0) ? '0 : t_csm - TimCsmWidth'(1);
  endfunction

endpackage

// File: rtl/hyperbus_down_counter.sv
// Loadable saturating down-counter with a registered zero flag.
module hyperbus_down_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/hyperbus_cs_seq.sv
// Chip-select / clock-enable sequencer with programmable CS setup, hold,
// recovery and optional maximum CS-low time, in the 90-degree PHY clock domain.
module hyperbus_cs_seq
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips     = 2,
  parameter int unsigned CntWidth     = 4,
  parameter int unsigned CsmWidth     = 10,
  parameter int unsigned ChipIdxWidth = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic                    clk_90_i,
  input  logic                    rst_ni,
  input  logic [CntWidth-1:0]     cfg_t_css_i,
  input  logic [CntWidth-1:0]     cfg_t_csh_i,
  input  logic [CntWidth-1:0]     cfg_t_cshi_i,
  input  logic [CsmWidth-1:0]     cfg_t_csm_i,
  input  logic                    cfg_csm_ena_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ChipIdxWidth-1:0] req_chip_i,
  input  logic                    release_i,
  input  logic                    abort_i,
  output logic                    active_o,
  output logic                    ck_ena_o,
  output logic [NumChips-1:0]     hyper_cs_no,
  output logic                    csm_expired_o,
  output logic                    req_err_o
);

  hyper_cs_state_e         state_q, state_d;
  hyper_cs_timing_t        timing_q, timing_d, cfg_timing;
  logic [ChipIdxWidth-1:0] chip_q, chip_d;
  logic [CsmWidth-1:0]     csm_q, csm_d, csm_lim;
  logic [NumChips-1:0]     cs_n_q, cs_n_d, sel_onehot;
  logic                    ck_ena_q, csm_expired_q, req_err_q;
  logic                    accept, chip_ok, start, expire, chip_err;
  logic                    cnt_load, cnt_dec, cnt_zero;
  logic [CntWidth-1:0]     cnt_val;

  assign accept  = req_valid_i & (state_q == IDLE);
  assign chip_ok = 32'(req_chip_i) < NumChips;
  assign start   = accept & chip_ok;

  // Snapshot of the configuration taken only when a transfer starts.
  always_comb begin
    cfg_timing         = DefaultTiming;
    cfg_timing.t_css   = TimCntWidth'(cfg_t_css_i);
    cfg_timing.t_csh   = TimCntWidth'(cfg_t_csh_i);
    cfg_timing.t_cshi  = TimCntWidth'(cfg_t_cshi_i);
    cfg_timing.t_csm   = TimCsmWidth'(cfg_t_csm_i);
    cfg_timing.csm_ena = cfg_csm_ena_i;
    timing_d           = start ? cfg_timing : timing_q;
    chip_d             = start ? req_chip_i : chip_q;
  end

  assign csm_lim = CsmWidth'(csm_last_cycle(timing_q.t_csm));

  hyperbus_down_counter #(
    .Width (CntWidth)
  ) i_phase_cnt (
    .clk_i      (clk_90_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state logic; abort outranks release, release outranks t_CSM expiry.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    csm_d    = csm_q;
    expire   = 1'b0;
    chip_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (chip_ok) begin
            state_d  = SETUP;
            cnt_load = 1'b1;
            cnt_val  = CntWidth'(timing_d.t_css);
          end else begin
            chip_err = 1'b1;
          end
        end
      end
      SETUP: begin
        if (abort_i) begin
          state_d  = RECOVER;
          cnt_load = 1'b1;
          cnt_val  = CntWidth'(timing_q.t_cshi);
        end else if (cnt_zero) begin
          state_d = ACTIVE;
          csm_d   = '0;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACTIVE: begin
        csm_d = csm_q + CsmWidth'(1);
        if (abort_i) begin
          state_d  = RECOVER;
          cnt_load = 1'b1;
          cnt_val  = CntWidth'(timing_q.t_cshi);
        end else if (release_i) begin
          state_d  = HOLD;
          cnt_load = 1'b1;
          cnt_val  = CntWidth'(timing_q.t_csh);
        end else if (timing_q.csm_ena && (csm_q == csm_lim)) begin
          state_d  = HOLD;
          cnt_load = 1'b1;
          cnt_val  = CntWidth'(timing_q.t_csh);
          expire   = 1'b1;
        end
      end
      HOLD: begin
        if (abort_i || cnt_zero) begin
          state_d  = RECOVER;
          cnt_load = 1'b1;
          cnt_val  = CntWidth'(timing_q.t_cshi);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RECOVER: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // CS follows the next state so it changes on the same edge as the phase.
  always_comb begin
    sel_onehot = NumChips'(1) << chip_d;
    cs_n_d     = '1;
    if (state_d inside {SETUP, ACTIVE, HOLD}) begin
      cs_n_d = ~sel_onehot;
    end
  end

  always_ff @(posedge clk_90_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      timing_q      <= DefaultTiming;
      chip_q        <= '0;
      csm_q         <= '0;
      cs_n_q        <= '1;
      ck_ena_q      <= 1'b0;
      csm_expired_q <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timing_q      <= timing_d;
      chip_q        <= chip_d;
      csm_q         <= csm_d;
      cs_n_q        <= cs_n_d;
      ck_ena_q      <= (state_d == ACTIVE);
      csm_expired_q <= expire;
      req_err_q     <= chip_err;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign hyper_cs_no   = cs_n_q;
  assign ck_ena_o      = ck_ena_q;
  assign active_o      = ck_ena_q;
  assign csm_expired_o = csm_expired_q;
  assign req_err_o     = req_err_q;

endmodule

// File: tb/tb_hyperbus_cs_seq.sv
// Scoreboard bench for hyperbus_cs_seq: a driver pushes the expected per-transfer
// waveform shape, a monitor measures the real one and compares.
module tb_hyperbus_cs_seq;

  localparam int NC  = 4;
  localparam int CIW = 3;
  localparam int CW  = 4;
  localparam int MW  = 10;
  localparam int INF = 1 << 30;

  logic          clk_90_i = 1'b0;
  logic          rst_ni;
  logic [CW-1:0] cfg_t_css_i, cfg_t_csh_i, cfg_t_cshi_i;
  logic [MW-1:0] cfg_t_csm_i;
  logic          cfg_csm_ena_i;
  logic          req_valid_i, req_ready_o;
  logic [CIW-1:0] req_chip_i;
  logic          release_i, abort_i, active_o, ck_ena_o, csm_expired_o, req_err_o;
  logic [NC-1:0] hyper_cs_no;

  hyperbus_cs_seq #(
    .NumChips(NC), .CntWidth(CW), .CsmWidth(MW), .ChipIdxWidth(CIW)
  ) dut (
    .clk_90_i(clk_90_i), .rst_ni(rst_ni),
    .cfg_t_css_i(cfg_t_css_i), .cfg_t_csh_i(cfg_t_csh_i), .cfg_t_cshi_i(cfg_t_cshi_i),
    .cfg_t_csm_i(cfg_t_csm_i), .cfg_csm_ena_i(cfg_csm_ena_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_chip_i(req_chip_i),
    .release_i(release_i), .abort_i(abort_i), .active_o(active_o), .ck_ena_o(ck_ena_o),
    .hyper_cs_no(hyper_cs_no), .csm_expired_o(csm_expired_o), .req_err_o(req_err_o)
  );

  always #5 clk_90_i = ~clk_90_i;

  typedef struct {
    bit err;
    int chip;
    int pre;
    int ck;
    int post;
    int exp;
    int rec;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   stray    = 0;

  task automatic check(input string nm, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
  endtask

  // Expected transfer shape in cycles, from the timing rules (j = cycles after accept).
  function automatic txn_t model(input int css, input int csh, input int cshi, input int csm,
                                 input bit ena, input int chip, input int rel_j, input int ab_j);
    txn_t t;
    int s, h, c, act_rel, act, low;
    t = '{default: 0};
    if (chip >= NC) begin
      t.err = 1'b1;
      return t;
    end
    s       = css + 1;
    h       = csh + 1;
    c       = ena ? ((csm == 0) ? 1 : csm) : INF;
    act_rel = (rel_j >= s) ? rel_j - s + 1 : INF;
    act     = (c < act_rel) ? c : act_rel;
    t.exp   = (c < act_rel) ? 1 : 0;
    t.chip  = chip;
    t.rec   = cshi + 1;
    if (ab_j >= 0 && ab_j < s + act + h) begin
      low    = ab_j + 1;
      t.pre  = (low < s) ? low : s;
      t.ck   = (low > s) ? ((low - s < act) ? low - s : act) : 0;
      t.post = low - t.pre - t.ck;
      if (ab_j < s + act) t.exp = 0;
    end else begin
      t.pre  = s;
      t.ck   = act;
      t.post = h;
    end
    return t;
  endfunction

  // Issue one request; cfg is scrambled right after accept to prove it was latched.
  task automatic txn(input int css, input int csh, input int cshi, input int csm, input bit ena,
                     input int chip, input int rel_j, input int ab_j);
    int w;
    int maxj;
    txn_t e;
    cfg_t_css_i   = CW'(css);
    cfg_t_csh_i   = CW'(csh);
    cfg_t_cshi_i  = CW'(cshi);
    cfg_t_csm_i   = MW'(csm);
    cfg_csm_ena_i = ena;
    req_chip_i    = CIW'(chip);
    req_valid_i   = 1'b1;
    w = 0;
    do begin
      @(negedge clk_90_i);
      w++;
    end while (!req_ready_o && w < 500);
    if (!req_ready_o) begin
      check("accept_timeout", 1, 0);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_90_i);
    #1;
    req_valid_i   = 1'b0;
    e = model(css, csh, cshi, csm, ena, chip, rel_j, ab_j);
    exp_q.push_back(e);
    cfg_t_css_i   = CW'($urandom);
    cfg_t_csh_i   = CW'($urandom);
    cfg_t_cshi_i  = CW'($urandom);
    cfg_t_csm_i   = MW'($urandom);
    cfg_csm_ena_i = 1'($urandom);
    if (e.err) return;
    maxj = (rel_j > ab_j) ? rel_j : ab_j;
    for (int j = 0; j <= maxj; j++) begin
      release_i = (j == rel_j);
      abort_i   = (j == ab_j);
      @(posedge clk_90_i);
      #1;
    end
    release_i = 1'b0;
    abort_i   = 1'b0;
  endtask

  // Monitor: measures each CS-low episode and the following recovery.
  initial begin : monitor
    int ph, pre, ck, post, expn, rec, chip, nz, bad;
    logic [NC-1:0] pat;
    txn_t e;
    ph = 0; pre = 0; ck = 0; post = 0; expn = 0; rec = 0; chip = 0; bad = 0; pat = '1;
    forever begin
      @(negedge clk_90_i);
      if (!rst_ni) begin
        ph = 0;
        continue;
      end
      if (ck_ena_o !== active_o) stray++;
      if (ph == 0) begin
        if (ck_ena_o) stray++;
        if (req_err_o) begin
          if (exp_q.size() == 0) check("unexpected_err", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("err_flag", 1, int'(e.err));
            check("err_cs_high", int'(hyper_cs_no == '1), 1);
          end
        end
        if (hyper_cs_no != '1) begin
          ph = 1; pre = 0; ck = 0; post = 0; expn = 0; rec = 0; bad = 0;
          pat = hyper_cs_no; nz = 0; chip = 0;
          for (int i = 0; i < NC; i++) if (!pat[i]) begin nz++; chip = i; end
          if (nz != 1) bad = 1;
        end
      end
      if (ph == 1) begin
        if (hyper_cs_no == '1) begin
          ph = 2;
        end else begin
          if (hyper_cs_no != pat || req_err_o) bad = 1;
          if (ck_ena_o) begin
            ck++;
            if (post > 0) bad = 1;
          end else if (ck == 0) pre++;
          else post++;
          if (csm_expired_o) begin
            expn++;
            if (!(ck > 0 && post == 1 && !ck_ena_o)) bad = 1;
          end
        end
      end
      if (ph == 2) begin
        if (ck_ena_o || csm_expired_o || req_err_o || hyper_cs_no != '1) bad = 1;
        if (!req_ready_o) rec++;
        else begin
          ph = 0;
          if (exp_q.size() == 0) check("unexpected_txn", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("err_flag", 0, int'(e.err));
            if (!e.err) begin
              check("chip", chip, e.chip);
              check("setup_cycles", pre, e.pre);
              check("ck_cycles", ck, e.ck);
              check("hold_cycles", post, e.post);
              check("csm_pulses", expn, e.exp);
              check("recover_cycles", rec, e.rec);
            end
            check("protocol", bad, 0);
          end
        end
      end
    end
  end

  initial begin : stim
    int css, csh, cshi, csm, chip, rel_j, ab_j, s, w;
    bit ena;
    rst_ni = 1'b0;
    cfg_t_css_i = '0; cfg_t_csh_i = '0; cfg_t_cshi_i = '0; cfg_t_csm_i = '0;
    cfg_csm_ena_i = 1'b0; req_valid_i = 1'b0; req_chip_i = '0;
    release_i = 1'b0; abort_i = 1'b0;
    #12;
    check("rst_cs", int'(hyper_cs_no), int'({NC{1'b1}}));
    check("rst_ck", int'(ck_ena_o), 0);
    check("rst_active", int'(active_o), 0);
    check("rst_csm", int'(csm_expired_o), 0);
    check("rst_err", int'(req_err_o), 0);
    #10 rst_ni = 1'b1;
    @(posedge clk_90_i);
    #1;
    check("ready_after_rst", int'(req_ready_o), 1);

    txn(2, 1, 3, 0, 0, 1, 7, -1);    // release after 5 active cycles
    txn(2, 1, 3, 8, 1, 0, -1, -1);   // t_CSM forced release
    txn(2, 1, 3, 8, 1, 1, 10, -1);   // release coincides with expiry
    txn(2, 1, 2, 0, 0, 1, 20, 1);    // abort in SETUP
    txn(2, 1, 2, 0, 0, 2, 20, 5);    // abort in ACTIVE
    txn(2, 3, 2, 0, 0, 0, 6, 8);     // abort in HOLD
    txn(1, 1, 1, 0, 0, 5, -1, -1);   // chip index out of range
    txn(1, 1, 1, 0, 0, 3, 4, -1);
    txn(1, 7, 1, 0, 0, 3, 4, -1);
    txn(0, 0, 0, 0, 1, 2, -1, -1);   // t_CSM = 0 acts as 1
    txn(0, 0, 0, 3, 1, 1, 25, 3);    // abort exactly on the expiry cycle

    for (int n = 0; n < 60; n++) begin
      css  = $urandom_range(0, 6);
      csh  = $urandom_range(0, 6);
      cshi = $urandom_range(0, 6);
      csm  = $urandom_range(0, 12);
      ena  = 1'($urandom);
      chip = ($urandom_range(0, 5) == 0) ? $urandom_range(NC, 7) : $urandom_range(0, NC - 1);
      s    = css + 1;
      rel_j = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, s + 14);
      if (!ena && rel_j < s) rel_j = s + $urandom_range(0, 10);
      ab_j = ($urandom_range(0, 3) == 0) ? $urandom_range(0, s + 16) : -1;
      txn(css, csh, cshi, csm, ena, chip, rel_j, ab_j);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk_90_i);
      w++;
    end
    check("drain", exp_q.size(), 0);
    #1;

    // Async reset in the middle of ACTIVE drops the transfer at once.
    cfg_t_css_i = CW'(1); cfg_t_csh_i = CW'(2); cfg_t_cshi_i = CW'(2);
    cfg_csm_ena_i = 1'b0; req_chip_i = CIW'(3); req_valid_i = 1'b1;
    w = 0;
    do begin
      @(negedge clk_90_i);
      w++;
    end while (!req_ready_o && w < 500);
    @(posedge clk_90_i);
    #1 req_valid_i = 1'b0;
    repeat (3) @(posedge clk_90_i);
    #1;
    check("pre_rst_ck", int'(ck_ena_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_cs", int'(hyper_cs_no), int'({NC{1'b1}}));
    check("async_rst_ck", int'(ck_ena_o), 0);
    check("async_rst_active", int'(active_o), 0);
    #4 rst_ni = 1'b1;
    @(posedge clk_90_i);
    #1;
    check("ready_after_async_rst", int'(req_ready_o), 1);
    txn(1, 2, 2, 0, 0, 3, 5, -1);
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk_90_i);
      w++;
    end
    check("drain_final", exp_q.size(), 0);
    check("stray_clock", stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
